sid_bus_bridge: RTL and testbench
=================================

SID_BUS_BRIDGE -- requirements
Module: sid_bus_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning write-FIFO entries; power of two, 2..256.
REQ-002 SHALL have port CLK  input  1  system clock (12 MHz); the block uses one clock only.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port RX_DATA  input  8  byte from the SPI slave.
REQ-005 SHALL have port RX_VALID  input  1  one-cycle strobe, RX_DATA valid.
REQ-006 SHALL have port CLKEN  input  1  1 MHz SID clock enable, one CLK cycle wide.
REQ-007 SHALL have port WR  output  1  SID write strobe.
REQ-008 SHALL have port ADDR  output  5  SID register address.
REQ-009 SHALL have port DATAW  output  8  SID write data.
REQ-010 SHALL have port LEVEL  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-011 SHALL decode headers `1AAAAADD` (ADDR=[6:2], DATA[7:6]=[1:0]) and data bytes `0xDDDDDD` (DATA[5:0]=[5:0]); bit 6 of a data byte is ignored.
REQ-012 SHALL run a parser FSM with states IDLE and HDR; header in IDLE -> HDR, latching address and high data bits.
REQ-013 SHALL, on a data byte in HDR, push {ADDR,DATA} into the FIFO and return to IDLE.
REQ-014 SHALL drop a data byte received in IDLE and flag a protocol error.
REQ-015 SHALL treat a header received in HDR as a replacement: the old header is discarded, the new one is latched, the FSM stays in HDR, and a protocol error is flagged.
REQ-016 SHALL drop a push when the FIFO is full, unless a pop occurs in the same cycle, in which case the push is accepted; a dropped push flags an overflow.
REQ-017 SHALL pop at most one entry per CLKEN pulse: on a cycle with CLKEN=1 and LEVEL>0, the head is popped.
REQ-018 SHALL assert WR for exactly one CLK cycle, the cycle after the pop, with ADDR/DATAW valid in that cycle.
REQ-019 SHALL hold ADDR/DATAW at their last written values while WR=0.
REQ-020 SHALL make a byte available for popping no earlier than 1 cycle after the RX_VALID that completed its pair.
REQ-021 SHALL wrap the FIFO pointers modulo DEPTH; LEVEL SHALL range 0..DEPTH.
REQ-022 SHALL preserve FIFO order exactly; no reordering or coalescing of writes to the same address.

Reset
REQ-023 SHALL on RST: FSM=IDLE, FIFO empty, LEVEL=0, WR=0, ADDR=0, DATAW=0, status cleared.
REQ-024 SHALL let RST override same-cycle RX_VALID and CLKEN; a half-received pair is discarded.

Configuration
REQ-025 SHALL, with macro SID_BRIDGE_STATUS_EN defined, add these ports:
- OVERFLOW (output 1): sticky flag.
- PROTO_ERR (output 1): sticky flag.
- ERR_COUNT (output 8): saturating at 255; increments once per overflow or protocol-error event, and once per cycle if both occur.
- CLR_ERR (input 1): clears all three; CLR_ERR loses to a same-cycle new error, so the flag is set and the count becomes 1.
REQ-026 SHALL, without SID_BRIDGE_STATUS_EN, omit those ports and drop bytes silently with identical data-path behaviour.

Structure
REQ-027 SHALL place the following in package sid_bus_pkg:
- parser state enum {IDLE,HDR};
- FIFO entry typedef (5-bit addr, 8-bit data);
- constants HDR_FLAG_BIT=7 and SID_ADDR_W=5.
REQ-028 SHALL implement storage in one sub-module sid_bus_fifo (synchronous FIFO with push/pop/level); parser and drain logic stay in sid_bus_bridge.

Verification
REQ-029 Single write: send 0x80|(0x04<<2)|0x2, then 0x15; CLKEN pulse -> one WR with ADDR=0x04, DATAW=0x95 one cycle after CLKEN.
REQ-030 Protocol errors:
- data byte 0x3F in IDLE -> no push, PROTO_ERR=1;
- header A then header B then data -> one write, to B's address.
REQ-031 Overflow, DEPTH=16, CLKEN held low:
- 17 pairs -> LEVEL=16, OVERFLOW=1, ERR_COUNT=1;
- then 16 CLKEN pulses -> 16 WRs in send order, LEVEL=0.
REQ-032 Full push/pop race: with LEVEL=16, complete a pair on the same cycle as a CLKEN pop -> LEVEL stays 16, no overflow.
REQ-033 Reset mid-pair: header, RST, data byte -> no write, PROTO_ERR=1; RST with LEVEL=5 -> LEVEL=0, no WR on next CLKEN.
REQ-034 Rate limit: 3 queued entries with CLKEN every 12 cycles -> WRs exactly 12 cycles apart, never two within one CLKEN period.

Source files
------------

// File: rtl/sid_bus_pkg.sv
// Shared types and constants for the SID bus bridge: parser states, FIFO entry
// layout and byte-format constants.
package sid_bus_pkg;

    localparam int HDR_FLAG_BIT = 7;
    localparam int SID_ADDR_W   = 5;
    localparam int SID_DATA_W   = 8;
    localparam int ENTRY_W      = SID_ADDR_W + SID_DATA_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HDR  = 1'b1
    } parse_state_t;

    typedef struct packed {
        logic [SID_ADDR_W-1:0] addr;
        logic [SID_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sid_bus_fifo.sv
// Synchronous FIFO holding decoded SID writes. A push into a full FIFO is only
// accepted when a pop happens in the same cycle; pointers wrap modulo DEPTH.
module sid_bus_fifo
    import sid_bus_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       pop_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        level_q;
    logic               full;
    logic               empty;
    logic               push_ok;
    logic               pop_ok;

    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == FULL_LVL);
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign level    = level_q;

endmodule

// File: rtl/sid_bus_bridge.sv
// SPI-byte to SID register-write bridge: pairs header/data bytes, queues them and
// drains one write per SID clock enable. Status ports exist with SID_BRIDGE_STATUS_EN.
module sid_bus_bridge
    import sid_bus_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [7:0]               RX_DATA,
    input  logic                     RX_VALID,
    input  logic                     CLKEN,
    output logic                     WR,
    output logic [4:0]               ADDR,
    output logic [7:0]               DATAW,
    output logic [$clog2(DEPTH):0]   LEVEL
`ifdef SID_BRIDGE_STATUS_EN
    ,
    output logic                     OVERFLOW,
    output logic                     PROTO_ERR,
    output logic [7:0]               ERR_COUNT,
    input  logic                     CLR_ERR
`endif
);

    localparam int LW = $clog2(DEPTH) + 1;

    parse_state_t          state_p0;
    logic [SID_ADDR_W-1:0] addr_p0;
    logic [1:0]            hi_p0;
    logic                  is_hdr;
    logic                  push_req;
    logic                  pop_en;
    fifo_entry_t           push_word;
    fifo_entry_t           pop_word;
    logic [LW-1:0]         fifo_level;
    logic                  wr_p1;
    logic [SID_ADDR_W-1:0] addr_p1;
    logic [SID_DATA_W-1:0] dataw_p1;

    // Stage 0: byte parser
    always_comb begin
        is_hdr         = RX_DATA[HDR_FLAG_BIT];
        push_req       = RX_VALID & ~is_hdr & (state_p0 == HDR) & ~RST;
        pop_en         = CLKEN & (fifo_level != '0) & ~RST;
        push_word.addr = addr_p0;
        push_word.data = {hi_p0, RX_DATA[5:0]};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_p0 <= IDLE;
        end else if (RX_VALID) begin
            state_p0 <= is_hdr ? HDR : IDLE;
        end
    end

    // A header always overwrites the latch, so a repeated header replaces the pending one.
    always_ff @(posedge CLK) begin
        if (RX_VALID && is_hdr) begin
            addr_p0 <= RX_DATA[6:2];
            hi_p0   <= RX_DATA[1:0];
        end
    end

    sid_bus_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push_req),
        .push_data (push_word),
        .pop       (pop_en),
        .pop_data  (pop_word),
        .level     (fifo_level)
    );

    // Stage 1: SID write register, loaded on the pop cycle and held between writes
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_p1    <= 1'b0;
            addr_p1  <= '0;
            dataw_p1 <= '0;
        end else begin
            wr_p1 <= pop_en;
            if (pop_en) begin
                addr_p1  <= pop_word.addr;
                dataw_p1 <= pop_word.data;
            end
        end
    end

    assign WR    = wr_p1;
    assign ADDR  = addr_p1;
    assign DATAW = dataw_p1;
    assign LEVEL = fifo_level;

`ifdef SID_BRIDGE_STATUS_EN
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic       proto_evt;
    logic       ovf_evt;
    logic       any_evt;
    logic       overflow_q;
    logic       proto_q;
    logic [7:0] err_cnt_q;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        proto_evt = RX_VALID & ~RST &
                    (((state_p0 == IDLE) & ~is_hdr) | ((state_p0 == HDR) & is_hdr));
        ovf_evt   = push_req & (fifo_level == FULL_LVL) & ~pop_en;
        any_evt   = proto_evt | ovf_evt;
    end

    // A new error wins over a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_q <= 1'b0;
            proto_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            overflow_q <= (overflow_q & ~CLR_ERR) | ovf_evt;
            proto_q    <= (proto_q & ~CLR_ERR) | proto_evt;
            if (any_evt) begin
                err_cnt_q <= CLR_ERR ? 8'd1 : sat_inc8(err_cnt_q);
            end else if (CLR_ERR) begin
                err_cnt_q <= '0;
            end
        end
    end

    assign OVERFLOW  = overflow_q;
    assign PROTO_ERR = proto_q;
    assign ERR_COUNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_sid_bus_bridge.sv
// Scoreboard bench for sid_bus_bridge; status-port checks are compiled in when
// SID_BRIDGE_STATUS_EN is defined.
module tb_sid_bus_bridge;

    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       CLKEN;
    wire        WR;
    wire  [4:0] ADDR;
    wire  [7:0] DATAW;
    wire  [4:0] LEVEL;
`ifdef SID_BRIDGE_STATUS_EN
    logic       CLR_ERR;
    wire        OVERFLOW;
    wire        PROTO_ERR;
    wire  [7:0] ERR_COUNT;
`endif

    sid_bus_bridge #(.DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .CLKEN    (CLKEN),
        .WR       (WR),
        .ADDR     (ADDR),
        .DATAW    (DATAW),
        .LEVEL    (LEVEL)
`ifdef SID_BRIDGE_STATUS_EN
        ,
        .OVERFLOW (OVERFLOW),
        .PROTO_ERR(PROTO_ERR),
        .ERR_COUNT(ERR_COUNT),
        .CLR_ERR  (CLR_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          exp_wr_total = 0;
    int          mdl_level = 0;
    logic [12:0] sb [$];
    int          wr_cyc [$];
    logic [12:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (WR === 1'b1) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_wr", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(ADDR), 32'(mon_e[12:8]));
                chk("wr_data", 32'(DATAW), 32'(mon_e[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic expect_push(input logic [4:0] a, input logic [7:0] d);
        if (mdl_level < DEPTH) begin
            sb.push_back({a, d});
            mdl_level++;
        end
    endtask

    // Bit 6 of the data byte is set from the address LSB to show it is ignored.
    task automatic send_pair(input logic [4:0] a, input logic [7:0] d);
        send_byte({1'b1, a, d[7:6]});
        send_byte({1'b0, a[0], d[5:0]});
        expect_push(a, d);
    endtask

    task automatic pulse_clken();
        logic exp_wr;
        exp_wr = (mdl_level > 0);
        CLKEN = 1'b1;
        tick();
        CLKEN = 1'b0;
        if (exp_wr) begin
            mdl_level--;
            exp_wr_total++;
        end
        @(negedge CLK);
        chk("wr_after_clken", 32'(WR), 32'(exp_wr));
        chk("level_after_pop", 32'(LEVEL), 32'(mdl_level));
        tick();
        @(negedge CLK);
        chk("wr_one_cycle", 32'(WR), 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        sb.delete();
        mdl_level = 0;
    endtask

`ifdef SID_BRIDGE_STATUS_EN
    task automatic clr_err();
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; RX_VALID = 1'b0; CLKEN = 1'b0; RX_DATA = 8'h00;
`ifdef SID_BRIDGE_STATUS_EN
        CLR_ERR = 1'b0;
`endif
        idle(2);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_level", 32'(LEVEL), 0);
        chk("rst_wr", 32'(WR), 0);
        chk("rst_addr", 32'(ADDR), 0);
        chk("rst_dataw", 32'(DATAW), 0);
`ifdef SID_BRIDGE_STATUS_EN
        chk("rst_ovf", 32'(OVERFLOW), 0);
        chk("rst_proto", 32'(PROTO_ERR), 0);
        chk("rst_cnt", 32'(ERR_COUNT), 0);
`endif

        // Single write: header 0x92, data 0x15 -> ADDR 0x04, DATAW 0x95
        send_byte(8'h92);
        send_byte(8'h15);
        sb.push_back({5'h04, 8'h95});
        mdl_level++;
        @(negedge CLK);
        chk("single_level", 32'(LEVEL), 1);
        pulse_clken();
        idle(2);
        @(negedge CLK);
        chk("hold_addr", 32'(ADDR), 32'h04);
        chk("hold_dataw", 32'(DATAW), 32'h95);

        // Data byte in IDLE is dropped
        send_byte(8'h3F);
        @(negedge CLK);
        chk("idle_data_level", 32'(LEVEL), 0);
`ifdef SID_BRIDGE_STATUS_EN
        chk("idle_data_proto", 32'(PROTO_ERR), 1);
        chk("idle_data_cnt", 32'(ERR_COUNT), 1);
`endif

        // Header A replaced by header B -> one write to B
        send_byte(8'h87);
        send_byte(8'hF9);
        send_byte(8'h2A);
        expect_push(5'h1E, 8'h6A);
        @(negedge CLK);
        chk("replace_level", 32'(LEVEL), 1);
`ifdef SID_BRIDGE_STATUS_EN
        chk("replace_cnt", 32'(ERR_COUNT), 2);
`endif
        pulse_clken();

`ifdef SID_BRIDGE_STATUS_EN
        clr_err();
        @(negedge CLK);
        chk("clr_proto", 32'(PROTO_ERR), 0);
        chk("clr_cnt", 32'(ERR_COUNT), 0);
        CLR_ERR = 1'b1;
        send_byte(8'h01);
        CLR_ERR = 1'b0;
        @(negedge CLK);
        chk("clr_race_proto", 32'(PROTO_ERR), 1);
        chk("clr_race_cnt", 32'(ERR_COUNT), 1);
        clr_err();
`endif

        // Overflow: 17 pairs with CLKEN low
        for (int i = 0; i < 17; i++) send_pair(5'(i), 8'(i * 13 + 7));
        @(negedge CLK);
        chk("ovf_level", 32'(LEVEL), 16);
`ifdef SID_BRIDGE_STATUS_EN
        chk("ovf_flag", 32'(OVERFLOW), 1);
        chk("ovf_cnt", 32'(ERR_COUNT), 1);
        clr_err();
`endif
        for (int i = 0; i < 16; i++) pulse_clken();
        @(negedge CLK);
        chk("drain_level", 32'(LEVEL), 0);
        chk("drain_sb", 32'(sb.size()), 0);

        // Full FIFO: pair completes on the same cycle as a pop
        for (int i = 0; i < 16; i++) send_pair(5'(31 - i), 8'(i * 29 + 3));
        send_byte({1'b1, 5'h0A, 2'b11});
        RX_DATA = 8'h05; RX_VALID = 1'b1; CLKEN = 1'b1;
        tick();
        RX_VALID = 1'b0; CLKEN = 1'b0;
        mdl_level--;
        exp_wr_total++;
        expect_push(5'h0A, 8'hC5);
        @(negedge CLK);
        chk("race_wr", 32'(WR), 1);
        chk("race_level", 32'(LEVEL), 16);
`ifdef SID_BRIDGE_STATUS_EN
        chk("race_ovf", 32'(OVERFLOW), 0);
`endif
        idle(1);
        for (int i = 0; i < 16; i++) pulse_clken();
        @(negedge CLK);
        chk("race_drain_level", 32'(LEVEL), 0);

        // Reset between header and data byte
        send_byte(8'hA5);
        do_reset();
        send_byte(8'h11);
        @(negedge CLK);
        chk("rst_mid_level", 32'(LEVEL), 0);
`ifdef SID_BRIDGE_STATUS_EN
        chk("rst_mid_proto", 32'(PROTO_ERR), 1);
`endif
        for (int i = 0; i < 5; i++) send_pair(5'(i + 3), 8'(i + 100));
        @(negedge CLK);
        chk("pre_rst_level", 32'(LEVEL), 5);
        do_reset();
        @(negedge CLK);
        chk("post_rst_level", 32'(LEVEL), 0);
        chk("post_rst_addr", 32'(ADDR), 0);
        chk("post_rst_dataw", 32'(DATAW), 0);
        pulse_clken();

        // Rate limit: CLKEN every 12 cycles
        for (int i = 0; i < 3; i++) send_pair(5'(i + 20), 8'(8'hF0 - 8'(i)));
        wr_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            pulse_clken();
            idle(10);
        end
        chk("rate_count", 32'(wr_cyc.size()), 3);
        if (wr_cyc.size() == 3) begin
            chk("rate_gap0", 32'(wr_cyc[1] - wr_cyc[0]), 12);
            chk("rate_gap1", 32'(wr_cyc[2] - wr_cyc[1]), 12);
        end

`ifdef SID_BRIDGE_STATUS_EN
        clr_err();
        for (int i = 0; i < 260; i++) send_byte(8'h02);
        @(negedge CLK);
        chk("cnt_saturate", 32'(ERR_COUNT), 255);
`endif

        idle(2);
        @(negedge CLK);
        chk("final_sb_empty", 32'(sb.size()), 0);
        chk("final_wr_total", 32'(wr_cnt), 32'(exp_wr_total));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
